// File: rtl/anabellek_yazma_tamponu.sv
//------------------------------------------------------------------------------
// Module   : anabellek_yazma_tamponu
// Purpose  : Posted-write buffer between the processor main-memory port and
//            external main memory. Writes are queued and acknowledged at
//            once; reads complete strictly behind every buffered write. The
//            queue drains in the background over the same valid/ready
//            protocol.
// Revision : 1.0 - initial release
//
// Ports    : clk, resetn          - clock, asynchronous active-low reset
//            s_valid_i/s_ready_o  - upstream request / one-cycle acknowledge
//            s_wstrb_i            - byte strobes (0 = read)
//            s_addr_i/s_wdata_i   - upstream address / write data
//            s_rdata_o            - read data, valid while s_ready_o=1
//            m_valid_o/m_ready_i  - downstream request / acknowledge
//            m_wstrb_o/m_addr_o/m_wdata_o/m_rdata_i - downstream payload
//            tampon_bos_o         - queue empty and no downstream transfer
//            doluluk_o            - current entry count
//
// Options  : YAZMA_TAMPONU_ILERI_AKTARIM_EN - when defined, a read that hits
//            a buffered full-word write returns that data directly without
//            draining the queue.
//------------------------------------------------------------------------------
`default_nettype none

module anabellek_yazma_tamponu #(
    parameter int DERINLIK = 4,
    parameter int SAYAC_W  = 3
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               s_valid_i,
    output logic               s_ready_o,
    input  logic [3:0]         s_wstrb_i,
    input  logic [31:0]        s_addr_i,
    input  logic [31:0]        s_wdata_i,
    output logic [31:0]        s_rdata_o,
    output logic               m_valid_o,
    input  logic               m_ready_i,
    output logic [3:0]         m_wstrb_o,
    output logic [31:0]        m_addr_o,
    output logic [31:0]        m_wdata_o,
    input  logic [31:0]        m_rdata_i,
    output logic               tampon_bos_o,
    output logic [SAYAC_W-1:0] doluluk_o
);

    localparam int                 PTR_W      = $clog2(DERINLIK);
    localparam logic [SAYAC_W-1:0] c_DERINLIK = SAYAC_W'(DERINLIK);

    typedef enum logic [1:0] {
        M_BOS = 2'd0,
        M_YAZ = 2'd1,
        M_OKU = 2'd2
    } m_durum_t;

    m_durum_t           durum_q;

    logic [31:0]        fifo_addr_q  [DERINLIK];
    logic [31:0]        fifo_wdata_q [DERINLIK];
    logic [3:0]         fifo_wstrb_q [DERINLIK];

    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [SAYAC_W-1:0] count_q,  count_d;

    logic               s_ready_q;
    logic [31:0]        s_rdata_q;
    logic               m_valid_q;
    logic [3:0]         m_wstrb_q;
    logic [31:0]        m_addr_q;
    logic [31:0]        m_wdata_q;

    logic               w_istek;
    logic               w_yazma;
    logic               w_okuma;
    logic               w_push;
    logic               w_pop;
    logic               w_oku_basla;
    logic               w_ileri_hit;
    logic [31:0]        w_ileri_veri;
    logic               w_ileri;

    // A request is only taken while s_ready_o is low, so the master still
    // holding valid during its acknowledge cycle is not seen twice.
    assign w_istek = s_valid_i && !s_ready_q;
    assign w_yazma = w_istek && (s_wstrb_i != 4'h0);
    assign w_okuma = w_istek && (s_wstrb_i == 4'h0);

    // Push looks at the count at cycle start only: a pop in the same cycle
    // does not open a slot until the next cycle.
    assign w_push  = w_yazma && (count_q < c_DERINLIK);

    // m_valid_q is always high in M_YAZ, so m_ready_i alone completes it.
    assign w_pop   = (durum_q == M_YAZ) && m_ready_i;

    assign w_ileri     = w_okuma && w_ileri_hit;
    assign w_oku_basla = w_okuma && !w_ileri_hit && (count_q == '0) &&
                         (durum_q == M_BOS);

`ifdef YAZMA_TAMPONU_ILERI_AKTARIM_EN
    logic [PTR_W-1:0] w_idx;

    // Walk valid entries oldest to youngest so the youngest address match
    // decides. A younger partial-strobe write to the same word cancels the
    // hit, since the full word in memory is then not known here.
    always_comb begin
        w_ileri_hit  = 1'b0;
        w_ileri_veri = '0;
        w_idx        = '0;
        for (int k = 0; k < DERINLIK; k++) begin
            if (SAYAC_W'(k) < count_q) begin
                w_idx = rd_ptr_q + PTR_W'(k);
                if (fifo_addr_q[w_idx][31:2] == s_addr_i[31:2]) begin
                    w_ileri_hit  = (fifo_wstrb_q[w_idx] == 4'hF);
                    w_ileri_veri = fifo_wdata_q[w_idx];
                end
            end
        end
    end
`else
    assign w_ileri_hit  = 1'b0;
    assign w_ileri_veri = '0;
`endif

    // Pointer and occupancy next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Entry storage carries no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (w_push) begin
            fifo_addr_q[wr_ptr_q]  <= s_addr_i;
            fifo_wdata_q[wr_ptr_q] <= s_wdata_i;
            fifo_wstrb_q[wr_ptr_q] <= s_wstrb_i;
        end
    end

    // Downstream master FSM with registered outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            durum_q   <= M_BOS;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            s_ready_q <= 1'b0;
            s_rdata_q <= '0;
            m_valid_q <= 1'b0;
            m_wstrb_q <= '0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            s_ready_q <= 1'b0;

            if (w_push) begin
                s_ready_q <= 1'b1;
            end
            if (w_ileri) begin
                s_ready_q <= 1'b1;
                s_rdata_q <= w_ileri_veri;
            end

            case (durum_q)
                M_BOS: begin
                    // Buffered writes always go first, preserving
                    // write-then-read ordering.
                    if (count_q != '0) begin
                        durum_q   <= M_YAZ;
                        m_valid_q <= 1'b1;
                        m_addr_q  <= fifo_addr_q[rd_ptr_q];
                        m_wdata_q <= fifo_wdata_q[rd_ptr_q];
                        m_wstrb_q <= fifo_wstrb_q[rd_ptr_q];
                    end else if (w_oku_basla) begin
                        durum_q   <= M_OKU;
                        m_valid_q <= 1'b1;
                        m_addr_q  <= s_addr_i;
                        m_wdata_q <= '0;
                        m_wstrb_q <= 4'h0;
                    end
                end
                M_YAZ: begin
                    if (m_ready_i) begin
                        durum_q   <= M_BOS;
                        m_valid_q <= 1'b0;
                    end
                end
                M_OKU: begin
                    if (m_ready_i) begin
                        durum_q   <= M_BOS;
                        m_valid_q <= 1'b0;
                        s_ready_q <= 1'b1;
                        s_rdata_q <= m_rdata_i;
                    end
                end
                default: begin
                    durum_q   <= M_BOS;
                    m_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign s_ready_o    = s_ready_q;
    assign s_rdata_o    = s_rdata_q;
    assign m_valid_o    = m_valid_q;
    assign m_wstrb_o    = m_wstrb_q;
    assign m_addr_o     = m_addr_q;
    assign m_wdata_o    = m_wdata_q;
    assign doluluk_o    = count_q;
    assign tampon_bos_o = (count_q == '0) && (durum_q == M_BOS);

endmodule

`default_nettype wire

// File: tb/tb_anabellek_yazma_tamponu.sv
//------------------------------------------------------------------------------
// Module   : tb_anabellek_yazma_tamponu
// Purpose  : Directed self-checking bench for anabellek_yazma_tamponu.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_anabellek_yazma_tamponu;

    logic        clk = 1'b0;
    logic        resetn;
    logic        s_valid_i;
    logic        s_ready_o;
    logic [3:0]  s_wstrb_i;
    logic [31:0] s_addr_i;
    logic [31:0] s_wdata_i;
    logic [31:0] s_rdata_o;
    logic        m_valid_o;
    logic        m_ready_i;
    logic [3:0]  m_wstrb_o;
    logic [31:0] m_addr_o;
    logic [31:0] m_wdata_o;
    logic [31:0] m_rdata_i;
    logic        tampon_bos_o;
    logic [2:0]  doluluk_o;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int rd_hs_cyc = -1;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
    } txn_t;

    txn_t mq[$];

    anabellek_yazma_tamponu #(
        .DERINLIK (4),
        .SAYAC_W  (3)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .s_valid_i    (s_valid_i),
        .s_ready_o    (s_ready_o),
        .s_wstrb_i    (s_wstrb_i),
        .s_addr_i     (s_addr_i),
        .s_wdata_i    (s_wdata_i),
        .s_rdata_o    (s_rdata_o),
        .m_valid_o    (m_valid_o),
        .m_ready_i    (m_ready_i),
        .m_wstrb_o    (m_wstrb_o),
        .m_addr_o     (m_addr_o),
        .m_wdata_o    (m_wdata_o),
        .m_rdata_i    (m_rdata_i),
        .tampon_bos_o (tampon_bos_o),
        .doluluk_o    (doluluk_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Downstream memory model: record every completed handshake.
    always @(negedge clk) begin
        if (resetn && m_valid_o && m_ready_i) begin
            mq.push_back({m_addr_o, m_wdata_o, m_wstrb_o});
            if (m_wstrb_o == 4'h0) rd_hs_cyc = cyc;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, output bit ok);
        s_valid_i = 1'b1;
        s_addr_i  = a;
        s_wdata_i = d;
        s_wstrb_i = s;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            step();
            if (s_ready_o) ok = 1'b1;
        end
        s_valid_i = 1'b0;
        s_wstrb_i = 4'h0;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            step();
            if (tampon_bos_o && !m_valid_o) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        bit seen;
        resetn    = 1'b0;
        m_ready_i = 1'b1;
        s_valid_i = 1'b0;
        repeat (3) step();
        checks++; if (s_ready_o !== 1'b0) begin failures++; $display("FAIL reset_s_ready got=%0h exp=0", s_ready_o); end
        checks++; if (s_rdata_o !== 32'h0) begin failures++; $display("FAIL reset_s_rdata got=%0h exp=0", s_rdata_o); end
        checks++; if (m_valid_o !== 1'b0) begin failures++; $display("FAIL reset_m_valid got=%0h exp=0", m_valid_o); end
        checks++; if (m_wstrb_o !== 4'h0) begin failures++; $display("FAIL reset_m_wstrb got=%0h exp=0", m_wstrb_o); end
        checks++; if (m_addr_o !== 32'h0) begin failures++; $display("FAIL reset_m_addr got=%0h exp=0", m_addr_o); end
        checks++; if (m_wdata_o !== 32'h0) begin failures++; $display("FAIL reset_m_wdata got=%0h exp=0", m_wdata_o); end
        checks++; if (tampon_bos_o !== 1'b1) begin failures++; $display("FAIL reset_bos got=%0h exp=1", tampon_bos_o); end
        checks++; if (doluluk_o !== 3'd0) begin failures++; $display("FAIL reset_doluluk got=%0d exp=0", doluluk_o); end
        resetn = 1'b1;
        seen = 1'b0;
        repeat (4) begin
            step();
            if (m_valid_o) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL reset_release_m_valid got=%0h exp=0", seen); end
        checks++; if (tampon_bos_o !== 1'b1) begin failures++; $display("FAIL reset_release_bos got=%0h exp=1", tampon_bos_o); end
        m_ready_i = 1'b0;
    endtask

    task automatic test_single_write();
        mq.delete();
        m_ready_i = 1'b0;
        s_valid_i = 1'b1;
        s_addr_i  = 32'h0000_0100;
        s_wdata_i = 32'hDEAD_BEEF;
        s_wstrb_i = 4'hF;
        step();  // N+1
        checks++; if (s_ready_o !== 1'b1) begin failures++; $display("FAIL wr_ack_n1 got=%0h exp=1", s_ready_o); end
        checks++; if (doluluk_o !== 3'd1) begin failures++; $display("FAIL wr_doluluk_n1 got=%0d exp=1", doluluk_o); end
        checks++; if (m_valid_o !== 1'b0) begin failures++; $display("FAIL wr_m_valid_n1 got=%0h exp=0", m_valid_o); end
        s_valid_i = 1'b0;
        s_wstrb_i = 4'h0;
        step();  // N+2
        checks++; if (s_ready_o !== 1'b0) begin failures++; $display("FAIL wr_ack_n2 got=%0h exp=0", s_ready_o); end
        checks++; if (m_valid_o !== 1'b1) begin failures++; $display("FAIL wr_m_valid_n2 got=%0h exp=1", m_valid_o); end
        checks++; if (m_addr_o !== 32'h0000_0100) begin failures++; $display("FAIL wr_m_addr got=%0h exp=100", m_addr_o); end
        checks++; if (m_wdata_o !== 32'hDEAD_BEEF) begin failures++; $display("FAIL wr_m_wdata got=%0h exp=deadbeef", m_wdata_o); end
        checks++; if (m_wstrb_o !== 4'hF) begin failures++; $display("FAIL wr_m_wstrb got=%0h exp=f", m_wstrb_o); end
        step();
        step();
        checks++; if ({m_valid_o, m_addr_o} !== {1'b1, 32'h0000_0100}) begin failures++; $display("FAIL wr_hold got=%0h exp=100000100", {m_valid_o, m_addr_o}); end
        m_ready_i = 1'b1;
        step();
        m_ready_i = 1'b0;
        checks++; if (m_valid_o !== 1'b0) begin failures++; $display("FAIL wr_m_valid_drop got=%0h exp=0", m_valid_o); end
        checks++; if (doluluk_o !== 3'd0) begin failures++; $display("FAIL wr_doluluk_end got=%0d exp=0", doluluk_o); end
        checks++; if (tampon_bos_o !== 1'b1) begin failures++; $display("FAIL wr_bos_end got=%0h exp=1", tampon_bos_o); end
        checks++; if (mq.size() != 1 || mq[0] !== {32'h0000_0100, 32'hDEAD_BEEF, 4'hF}) begin failures++; $display("FAIL wr_mem_rx got_n=%0d exp_n=1", mq.size()); end
    endtask

    task automatic test_full_buffer();
        bit ok;
        bit stalled;
        int acks;
        mq.delete();
        m_ready_i = 1'b0;
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            do_write(32'h0000_1000 + 32'(4 * i), 32'hA000_0000 + 32'(i), 4'hF, ok);
            if (ok) acks++;
        end
        checks++; if (acks != 4) begin failures++; $display("FAIL full_acks got=%0d exp=4", acks); end
        checks++; if (doluluk_o !== 3'd4) begin failures++; $display("FAIL full_doluluk got=%0d exp=4", doluluk_o); end
        s_valid_i = 1'b1;
        s_addr_i  = 32'h0000_1010;
        s_wdata_i = 32'hA000_0004;
        s_wstrb_i = 4'hF;
        stalled = 1'b1;
        repeat (4) begin
            step();
            if (s_ready_o) stalled = 1'b0;
        end
        checks++; if (stalled !== 1'b1) begin failures++; $display("FAIL full_stall got=%0h exp=1", stalled); end
        m_ready_i = 1'b1;
        step();  // pop completes, push still blocked this cycle
        m_ready_i = 1'b0;
        checks++; if (s_ready_o !== 1'b0) begin failures++; $display("FAIL full_no_same_cycle_push got=%0h exp=0", s_ready_o); end
        checks++; if (doluluk_o !== 3'd3) begin failures++; $display("FAIL full_after_pop got=%0d exp=3", doluluk_o); end
        step();
        checks++; if (s_ready_o !== 1'b1) begin failures++; $display("FAIL full_fifth_ack got=%0h exp=1", s_ready_o); end
        checks++; if (doluluk_o !== 3'd4) begin failures++; $display("FAIL full_refill got=%0d exp=4", doluluk_o); end
        s_valid_i = 1'b0;
        s_wstrb_i = 4'h0;
        m_ready_i = 1'b1;
        wait_idle(ok);
        m_ready_i = 1'b0;
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL full_drain_timeout got=%0h exp=1", ok); end
        checks++; if (mq.size() != 5) begin failures++; $display("FAIL full_mem_count got=%0d exp=5", mq.size()); end
        for (int i = 0; i < 5 && i < mq.size(); i++) begin
            checks++;
            if (mq[i] !== {32'h0000_1000 + 32'(4 * i), 32'hA000_0000 + 32'(i), 4'hF}) begin
                failures++;
                $display("FAIL full_mem_order[%0d] got=%0h/%0h exp=%0h/%0h", i, mq[i].a, mq[i].d,
                         32'h0000_1000 + 32'(4 * i), 32'hA000_0000 + 32'(i));
            end
        end
    endtask

    task automatic test_read_after_writes();
        bit ok1;
        bit ok2;
        bit got;
        mq.delete();
        rd_hs_cyc = -1;
        m_ready_i = 1'b0;
        m_rdata_i = 32'h1234_5678;
        do_write(32'h0000_0300, 32'h0000_0011, 4'hF, ok1);
        do_write(32'h0000_0304, 32'h0000_0022, 4'hF, ok2);
        checks++; if ({ok1, ok2} !== 2'b11) begin failures++; $display("FAIL rd_writes_ack got=%0b exp=11", {ok1, ok2}); end
        s_valid_i = 1'b1;
        s_addr_i  = 32'h0000_0200;
        s_wdata_i = 32'h0;
        s_wstrb_i = 4'h0;
        repeat (3) step();
        checks++; if ({m_valid_o, m_wstrb_o, m_addr_o} !== {1'b1, 4'hF, 32'h0000_0300}) begin failures++; $display("FAIL rd_waits_for_drain got=%0h exp=1f00000300", {m_valid_o, m_wstrb_o, m_addr_o}); end
        checks++; if (s_ready_o !== 1'b0) begin failures++; $display("FAIL rd_early_ack got=%0h exp=0", s_ready_o); end
        m_ready_i = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            step();
            if (s_ready_o) got = 1'b1;
        end
        s_valid_i = 1'b0;
        m_ready_i = 1'b0;
        checks++; if (got !== 1'b1) begin failures++; $display("FAIL rd_ack_timeout got=%0h exp=1", got); end
        checks++; if (s_rdata_o !== 32'h1234_5678) begin failures++; $display("FAIL rd_rdata got=%0h exp=12345678", s_rdata_o); end
        checks++; if (cyc != rd_hs_cyc + 1) begin failures++; $display("FAIL rd_latency got=%0d exp=%0d", cyc, rd_hs_cyc + 1); end
        checks++;
        if (mq.size() != 3 || mq[0].a !== 32'h0000_0300 || mq[1].a !== 32'h0000_0304 ||
            mq[2].a !== 32'h0000_0200 || mq[2].s !== 4'h0) begin
            failures++;
            $display("FAIL rd_order got_n=%0d exp_n=3", mq.size());
        end
        step();
        checks++; if (s_ready_o !== 1'b0) begin failures++; $display("FAIL rd_ack_pulse got=%0h exp=0", s_ready_o); end
    endtask

    task automatic test_forwarding();
        bit ok1;
        bit ok2;
        mq.delete();
        m_ready_i = 1'b0;
        m_rdata_i = 32'h5A5A_0000;
        do_write(32'h0000_0040, 32'hAAAA_5555, 4'hF, ok1);
        do_write(32'h0000_0040, 32'h1111_2222, 4'hF, ok2);
        checks++; if ({ok1, ok2} !== 2'b11) begin failures++; $display("FAIL fwd_writes_ack got=%0b exp=11", {ok1, ok2}); end
        s_valid_i = 1'b1;
        s_addr_i  = 32'h0000_0040;
        s_wstrb_i = 4'h0;
        step();  // N+1
`ifdef YAZMA_TAMPONU_ILERI_AKTARIM_EN
        s_valid_i = 1'b0;
        checks++; if (s_ready_o !== 1'b1) begin failures++; $display("FAIL fwd_ack got=%0h exp=1", s_ready_o); end
        checks++; if (s_rdata_o !== 32'h1111_2222) begin failures++; $display("FAIL fwd_rdata got=%0h exp=11112222", s_rdata_o); end
        checks++; if (doluluk_o !== 3'd2) begin failures++; $display("FAIL fwd_no_drain got=%0d exp=2", doluluk_o); end
        m_ready_i = 1'b1;
        wait_idle(ok1);
        m_ready_i = 1'b0;
        checks++; if (mq.size() != 2 || mq[0].s !== 4'hF || mq[1].s !== 4'hF) begin failures++; $display("FAIL fwd_no_mem_read got_n=%0d exp_n=2", mq.size()); end
`else
        checks++; if (s_ready_o !== 1'b0) begin failures++; $display("FAIL nofwd_early_ack got=%0h exp=0", s_ready_o); end
        m_ready_i = 1'b1;
        ok1 = 1'b0;
        for (int i = 0; i < 30 && !ok1; i++) begin
            step();
            if (s_ready_o) ok1 = 1'b1;
        end
        s_valid_i = 1'b0;
        m_ready_i = 1'b0;
        checks++; if (ok1 !== 1'b1) begin failures++; $display("FAIL nofwd_ack_timeout got=%0h exp=1", ok1); end
        checks++; if (s_rdata_o !== 32'h5A5A_0000) begin failures++; $display("FAIL nofwd_rdata got=%0h exp=5a5a0000", s_rdata_o); end
        checks++;
        if (mq.size() != 3 || mq[0].d !== 32'hAAAA_5555 || mq[1].d !== 32'h1111_2222 ||
            mq[2].s !== 4'h0 || mq[2].a !== 32'h0000_0040) begin
            failures++;
            $display("FAIL nofwd_order got_n=%0d exp_n=3", mq.size());
        end
`endif
    endtask

    task automatic test_mid_reset();
        bit ok;
        bit seen;
        int acks;
        m_ready_i = 1'b0;
        acks = 0;
        for (int i = 0; i < 3; i++) begin
            do_write(32'h0000_0500 + 32'(4 * i), 32'hB000_0000 + 32'(i), 4'hF, ok);
            if (ok) acks++;
        end
        checks++; if (acks != 3) begin failures++; $display("FAIL mrst_acks got=%0d exp=3", acks); end
        checks++; if ({m_valid_o, doluluk_o} !== {1'b1, 3'd3}) begin failures++; $display("FAIL mrst_busy got=%0h exp=b", {m_valid_o, doluluk_o}); end
        resetn = 1'b0;
        #1;
        checks++; if (m_valid_o !== 1'b0) begin failures++; $display("FAIL mrst_m_valid got=%0h exp=0", m_valid_o); end
        checks++; if (doluluk_o !== 3'd0) begin failures++; $display("FAIL mrst_doluluk got=%0d exp=0", doluluk_o); end
        checks++; if (tampon_bos_o !== 1'b1) begin failures++; $display("FAIL mrst_bos got=%0h exp=1", tampon_bos_o); end
        step();
        step();
        resetn = 1'b1;
        mq.delete();
        m_ready_i = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            step();
            if (m_valid_o) seen = 1'b1;
        end
        m_ready_i = 1'b0;
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL mrst_stale_valid got=%0h exp=0", seen); end
        checks++; if (mq.size() != 0) begin failures++; $display("FAIL mrst_stale_writes got=%0d exp=0", mq.size()); end
        checks++; if (doluluk_o !== 3'd0) begin failures++; $display("FAIL mrst_doluluk_after got=%0d exp=0", doluluk_o); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        resetn    = 1'b0;
        s_valid_i = 1'b0;
        s_wstrb_i = 4'h0;
        s_addr_i  = 32'h0;
        s_wdata_i = 32'h0;
        m_ready_i = 1'b0;
        m_rdata_i = 32'h0;
        test_reset();
        test_single_write();
        test_full_buffer();
        test_read_after_writes();
        test_forwarding();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
